// File: rtl/FLP_pkg.sv
// Shared floating-point datapath definitions: IEEE-754 single-precision word
// width and the state encoding of the adder issuer.
package FLP_pkg;

  localparam int OVERALL_BITS = 32;

  typedef enum logic [1:0] {
    ISSUER_IDLE  = 2'd0,
    ISSUER_RUN   = 2'd1,
    ISSUER_DRAIN = 2'd2
  } flp_issuer_state_t;

endpackage

// File: rtl/flp_result_fifo.sv
// Synchronous result FIFO: registered storage (not reset), head visible the
// cycle after a push, occupancy count exported for credit accounting.
module flp_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flp_adder_issuer.sv
// Issues operand bursts into the pipelined FLP adder and buffers its results,
// throttled by a credit limit. Build option FLP_ISSUER_ERR_CHECK_EN enables err.
module flp_adder_issuer
  import FLP_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_start,
  input  logic [LEN_BITS-1:0]     cmd_len,
  output logic                    cmd_busy,
  output logic                    cmd_done,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [OVERALL_BITS-1:0] op_a,
  input  logic [OVERALL_BITS-1:0] op_b,
  output logic                    adder_start,
  output logic [OVERALL_BITS-1:0] adder_a,
  output logic [OVERALL_BITS-1:0] adder_b,
  input  logic [OVERALL_BITS-1:0] adder_result,
  input  logic                    adder_done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OVERALL_BITS-1:0] res_data,
  output logic                    err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);

  flp_issuer_state_t   state;
  flp_issuer_state_t   state_nxt;
  logic [LEN_BITS-1:0] issue_rem;
  logic [LEN_BITS-1:0] out_rem;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       fifo_cnt;
  logic                fifo_empty;
  logic                fifo_full;
  logic                op_fire;
  logic                push;
  logic                pop;
  logic                done_nxt;

  // Credit: every issued op owns a FIFO slot until its result is popped.
  assign op_ready  = (state == ISSUER_RUN) && (issue_rem != '0) &&
                     (({1'b0, inflight} + {1'b0, fifo_cnt}) < CREDIT_LIMIT);
  assign op_fire   = op_valid && op_ready;
  assign push      = adder_done && (inflight != '0);
  assign res_valid = !fifo_empty;
  assign pop       = res_valid && res_ready;
  assign cmd_busy  = (state != ISSUER_IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      ISSUER_IDLE: begin
        if (cmd_start) begin
          if (cmd_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ISSUER_RUN;
          end
        end
      end
      ISSUER_RUN: begin
        if (op_fire && (issue_rem == LEN_BITS'(1))) begin
          state_nxt = ISSUER_DRAIN;
        end
      end
      ISSUER_DRAIN: begin
        if (pop && (out_rem == LEN_BITS'(1))) begin
          state_nxt = ISSUER_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ISSUER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ISSUER_IDLE;
      cmd_done    <= 1'b0;
      issue_rem   <= '0;
      out_rem     <= '0;
      inflight    <= '0;
      adder_start <= 1'b0;
      adder_a     <= '0;
      adder_b     <= '0;
    end else begin
      state       <= state_nxt;
      cmd_done    <= done_nxt;
      adder_start <= op_fire;
      if (op_fire) begin
        adder_a <= op_a;
        adder_b <= op_b;
      end
      if ((state == ISSUER_IDLE) && cmd_start) begin
        issue_rem <= cmd_len;
        out_rem   <= cmd_len;
      end else begin
        if (op_fire) begin
          issue_rem <= issue_rem - LEN_BITS'(1);
        end
        if (pop && (out_rem != '0)) begin
          out_rem <= out_rem - LEN_BITS'(1);
        end
      end
      case ({op_fire, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  flp_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OVERALL_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push && !fifo_full),
    .push_data (adder_result),
    .pop       (pop),
    .head      (res_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_cnt)
  );

`ifdef FLP_ISSUER_ERR_CHECK_EN
  // Sticky: stray adder result or a push the credit scheme should have prevented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if ((adder_done && (inflight == '0)) || (push && fifo_full)) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_flp_adder_issuer.sv
// Scoreboard bench for flp_adder_issuer with a fixed-latency adder stub.
module tb_flp_adder_issuer;
  import FLP_pkg::*;

  localparam int DEPTH = 8;
  localparam int LB    = 16;
  localparam int LAT   = 4;
  localparam int W     = OVERALL_BITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_start;
  logic [LB-1:0] cmd_len;
  logic          cmd_busy, cmd_done;
  logic          op_valid, op_ready;
  logic [W-1:0]  op_a, op_b;
  logic          adder_start;
  logic [W-1:0]  adder_a, adder_b, adder_result;
  logic          adder_done;
  logic          res_valid, res_ready;
  logic [W-1:0]  res_data;
  logic          err;

  always #5 clk = ~clk;

  flp_adder_issuer #(.FIFO_DEPTH(DEPTH), .LEN_BITS(LB)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .adder_start(adder_start), .adder_a(adder_a),
    .adder_b(adder_b), .adder_result(adder_result), .adder_done(adder_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .err(err)
  );

  // Hand-computed single-precision vectors: 1+2=3, 3.5-1.5=2, 0+0=0, -2-2=-4
  logic [W-1:0] dir_a   [4] = '{32'h3F800000, 32'h40600000, 32'h00000000, 32'hC0000000};
  logic [W-1:0] dir_b   [4] = '{32'h40000000, 32'hBFC00000, 32'h00000000, 32'hC0000000};
  logic [W-1:0] dir_sum [4] = '{32'h40400000, 32'h40000000, 32'h00000000, 32'hC0800000};

  function automatic logic [W-1:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40600000 && b == 32'hBFC00000) return 32'h40000000;
    if (a == 32'hC0000000 && b == 32'hC0000000) return 32'hC0800000;
    return a + b;
  endfunction

  // Adder stub: fixed latency, never reset (like the real pipeline)
  logic [LAT-1:0] pipe_v = '0;
  logic [W-1:0]   pipe_r [LAT];
  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], adder_start};
    pipe_r[0] <= adder_model(adder_a, adder_b);
    for (int i = 1; i < LAT; i++) pipe_r[i] <= pipe_r[i-1];
  end
  assign adder_done   = pipe_v[LAT-1];
  assign adder_result = pipe_r[LAT-1];

  int n_chk = 0, n_pass = 0;
  logic [W-1:0] exp_q [$];
  bit directed = 1'b0;
  int n_iss = 0, n_pop = 0, n_done = 0, n_starts = 0, n_resv = 0, outstanding = 0;
  int burst_id = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic monitor_step();
    logic [W-1:0] e;
    if (reset) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      if (op_valid && op_ready) begin
        e = directed ? dir_sum[(n_iss - 0) % 4] : op_a + op_b;
        exp_q.push_back(e);
        n_iss++;
        outstanding++;
        check("credit_bound", 32'(outstanding <= DEPTH), 32'd1);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL result_extra: got %h expected no result", res_data);
        end else begin
          check("result", res_data, exp_q.pop_front());
        end
        n_pop++;
        outstanding--;
      end
      if (cmd_done) begin
        n_done++;
        check("busy_at_done", 32'(cmd_busy), 32'd0);
      end
      if (adder_start) n_starts++;
      if (res_valid) n_resv++;
    end
  endtask

  task automatic do_burst(input int len, input bit dir, input bit rnd, input int stall, input bit restart);
    int iss0, pop0, done0, st0, idx;
    bit fin;
    burst_id++;
    iss0 = n_iss; pop0 = n_pop; done0 = n_done; st0 = n_starts;
    cmd_start = 1'b1;
    cmd_len   = LB'(len);
    @(posedge clk); #1;
    cmd_start = 1'b0;
    fin = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      idx = n_iss - iss0;
      op_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dir && idx < 4) begin
        op_a = dir_a[idx];
        op_b = dir_b[idx];
      end else begin
        op_a = {8'hA5, 8'(burst_id), 16'(idx)};
        op_b = 32'(idx * 7);
      end
      res_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      cmd_start = (restart && cyc == 3);
      if (restart && cyc == 3) cmd_len = LB'(7);
      if (stall > 0 && cyc == stall - 1) begin
        check("stall_issues", 32'(n_iss - iss0), 32'(DEPTH));
        check("stall_op_ready", 32'(op_ready), 32'd0);
      end
      @(posedge clk); #1;
      if (!cmd_busy && cyc >= 1) fin = 1'b1;
    end
    cmd_start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    op_valid = 1'b0;
    res_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("burst_finished", 32'(fin), 32'd1);
    check("issued", 32'(n_iss - iss0), 32'(len));
    check("adder_starts", 32'(n_starts - st0), 32'(len));
    check("popped", 32'(n_pop - pop0), 32'(len));
    check("done_pulses", 32'(n_done - done0), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("err_clear", 32'(err), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(cmd_busy), 32'd0);
    check({tag, "_done"}, 32'(cmd_done), 32'd0);
    check({tag, "_op_ready"}, 32'(op_ready), 32'd0);
    check({tag, "_adder_start"}, 32'(adder_start), 32'd0);
    check({tag, "_adder_a"}, adder_a, 32'd0);
    check({tag, "_adder_b"}, adder_b, 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int resv0, iss0;
    logic exp_err;
    reset = 1'b1; cmd_start = 1'b0; cmd_len = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none
    repeat (3) @(posedge clk); #1;
    check_reset_values("por");
    reset = 1'b0;
    @(posedge clk); #1;

    directed = 1'b1;
    do_burst(4, 1'b1, 1'b0, 0, 1'b0);
    directed = 1'b0;
    do_burst(0, 1'b0, 1'b0, 0, 1'b0);
    do_burst(20, 1'b0, 1'b0, 30, 1'b0);
    do_burst(100, 1'b0, 1'b1, 0, 1'b0);
    do_burst(5, 1'b0, 1'b0, 0, 1'b1);

    // Reset with three ops inside the adder pipeline
    iss0 = n_iss;
    cmd_start = 1'b1; cmd_len = LB'(10);
    @(posedge clk); #1;
    cmd_start = 1'b0;
    op_valid = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222;
    repeat (3) begin @(posedge clk); #1; end
    op_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_issued", 32'(n_iss - iss0), 32'd3);
    reset = 1'b1;
    #1;
    check_reset_values("mid");
    @(posedge clk); #1;
    reset = 1'b0;
    resv0 = n_resv;
    repeat (10) begin @(posedge clk); #1; end
    check("stray_dropped", 32'(n_resv - resv0), 32'd0);
    check("post_reset_busy", 32'(cmd_busy), 32'd0);
`ifdef FLP_ISSUER_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    check("stray_err", 32'(err), 32'(exp_err));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_burst(6, 1'b0, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
